// File: rtl/countdown_pkg.sv
// Shared types and constants for the multi-channel countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } cd_state_t;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

endpackage

// File: rtl/countdown_channel.sv
// One countdown channel: state machine, h/m/s value, reload value and a
// registered one-cycle expiry pulse. Commands arrive only when sel_hit is set.
module countdown_channel
  import countdown_pkg::*;
#(
  parameter int MAX_HOURS = 23,
  parameter int HW        = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          sel_hit,
  input  logic          start,
  input  logic          pause,
  input  logic          clear,
  input  logic          plus,
  input  logic          minus,
  input  logic          repeat_en,
  output logic [HW-1:0] hours,
  output logic [5:0]    mins,
  output logic [5:0]    secs,
  output logic          running,
  output logic          done,
  output logic          expired
);

  localparam logic [HW-1:0] H_MAX = HW'(MAX_HOURS);
  localparam logic [5:0]    M_MAX = 6'(MIN_MAX);
  localparam logic [5:0]    S_MAX = 6'(SEC_MAX);

  cd_state_t     state_q, state_d;
  logic [HW-1:0] h_q, h_d, rh_q, rh_d;
  logic [5:0]    m_q, m_d, s_q, s_d;
  logic [5:0]    rm_q, rm_d, rs_q, rs_d;
  logic          exp_q, exp_d;
  logic          value_zero, value_one, reload_zero;

  assign value_zero  = (h_q == '0) && (m_q == '0) && (s_q == '0);
  assign value_one   = (h_q == '0) && (m_q == '0) && (s_q == 6'd1);
  assign reload_zero = (rh_q == '0) && (rm_q == '0) && (rs_q == '0);

  // State and value registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      h_q     <= '0;
      m_q     <= '0;
      s_q     <= '0;
      rh_q    <= '0;
      rm_q    <= '0;
      rs_q    <= '0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      m_q     <= m_d;
      s_q     <= s_d;
      rh_q    <= rh_d;
      rm_q    <= rm_d;
      rs_q    <= rs_d;
      exp_q   <= exp_d;
    end
  end

  // Next state: the highest-priority addressed command wins and suppresses the tick.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    m_d     = m_q;
    s_d     = s_q;
    rh_d    = rh_q;
    rm_d    = rm_q;
    rs_d    = rs_q;
    exp_d   = 1'b0;

    if (sel_hit && clear) begin
      state_d = IDLE;
      h_d     = '0;
      m_d     = '0;
      s_d     = '0;
      rh_d    = '0;
      rm_d    = '0;
      rs_d    = '0;
    end else if (sel_hit && pause) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (sel_hit && start) begin
      case (state_q)
        IDLE: begin
          if (!value_zero) begin
            state_d = RUN;
            rh_d    = h_q;
            rm_d    = m_q;
            rs_d    = s_q;
          end
        end
        PAUSE: begin
          if (!value_zero) state_d = RUN;
        end
        DONE: begin
          if (!reload_zero) begin
            state_d = RUN;
            h_d     = rh_q;
            m_d     = rm_q;
            s_d     = rs_q;
          end
        end
        default: begin
        end
      endcase
    end else if (sel_hit && plus) begin
      if (state_q != RUN) begin
        if (state_q == DONE) state_d = IDLE;
        if (h_q >= H_MAX && m_q == M_MAX) begin
          h_d = H_MAX;
          m_d = M_MAX;
          s_d = S_MAX;
        end else if (m_q == M_MAX) begin
          m_d = '0;
          h_d = h_q + 1'b1;
        end else begin
          m_d = m_q + 1'b1;
        end
      end
    end else if (sel_hit && minus) begin
      if (state_q == IDLE || state_q == PAUSE) begin
        if (h_q == '0 && m_q == '0) begin
          s_d = '0;
        end else if (m_q == '0) begin
          m_d = M_MAX;
          h_d = h_q - 1'b1;
        end else begin
          m_d = m_q - 1'b1;
        end
      end
    end else if (tick && state_q == RUN) begin
      if (value_one || value_zero) begin
        exp_d = 1'b1;
        if (repeat_en) begin
          h_d = rh_q;
          m_d = rm_q;
          s_d = rs_q;
        end else begin
          state_d = DONE;
          h_d     = '0;
          m_d     = '0;
          s_d     = '0;
        end
      end else if (s_q != '0) begin
        s_d = s_q - 1'b1;
      end else if (m_q != '0) begin
        s_d = S_MAX;
        m_d = m_q - 1'b1;
      end else begin
        s_d = S_MAX;
        m_d = M_MAX;
        h_d = h_q - 1'b1;
      end
    end
  end

  assign hours   = h_q;
  assign mins    = m_q;
  assign secs    = s_q;
  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign expired = exp_q;

endmodule

// File: rtl/multi_channel_countdown.sv
// Multi-channel countdown timer: shared 1 s prescaler, CHANNELS independent
// channels, and a combinational display mux driven by sel.
module multi_channel_countdown
  import countdown_pkg::*;
#(
  parameter int  CLK_HZ    = 50000000,
  parameter int  CHANNELS  = 2,
  parameter int  MAX_HOURS = 23,
  localparam int HW        = $clog2(MAX_HOURS + 1),
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CW-1:0]       sel,
  input  logic                start,
  input  logic                pause,
  input  logic                clear,
  input  logic                plus,
  input  logic                minus,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [HW-1:0]       hours,
  output logic [5:0]          mins,
  output logic [5:0]          secs,
  output logic [CHANNELS-1:0] running,
  output logic [CHANNELS-1:0] expired,
  output logic                alarm
);

  localparam int            PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0]       pre_q;
  logic                tick;
  logic [HW-1:0]       ch_hours [CHANNELS];
  logic [5:0]          ch_mins  [CHANNELS];
  logic [5:0]          ch_secs  [CHANNELS];
  logic [CHANNELS-1:0] ch_done;

  assign tick = (pre_q == PRE_LAST);

  // Shared prescaler wrapping every CLK_HZ cycles; tick marks its last count.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    countdown_channel #(
      .MAX_HOURS (MAX_HOURS),
      .HW        (HW)
    ) u_channel (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .sel_hit   (sel == CW'(i)),
      .start     (start),
      .pause     (pause),
      .clear     (clear),
      .plus      (plus),
      .minus     (minus),
      .repeat_en (repeat_en[i]),
      .hours     (ch_hours[i]),
      .mins      (ch_mins[i]),
      .secs      (ch_secs[i]),
      .running   (running[i]),
      .done      (ch_done[i]),
      .expired   (expired[i])
    );
  end

  // Display mux: the addressed channel's time, zeros for an unused sel code.
  always_comb begin
    hours = '0;
    mins  = '0;
    secs  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == CW'(i)) begin
        hours = ch_hours[i];
        mins  = ch_mins[i];
        secs  = ch_secs[i];
      end
    end
  end

  assign alarm = |ch_done;

endmodule
